// File: rtl/l2_cache_dir_sharers_if.sv
// Request bundle that travels between pipeline stages around the L2 directory.
// The tag stage drives the master side. The directory consumes it as slave and re-drives a registered copy as master.
interface l2_cache_dir_sharers_if #(
   parameter int unsigned NUM_WAYS  = 4,
   parameter int unsigned NUM_CORES = 2
);
   localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
   localparam int unsigned CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic              l2req_valid;
   logic [CORE_W-1:0] l2req_core;
   logic [1:0]        l2req_unit;
   logic [1:0]        l2req_strand;
   logic [2:0]        l2req_op;
   logic [1:0]        l2req_way;
   logic [25:0]       l2req_address;
   logic [511:0]      l2req_data;
   logic [63:0]       l2req_mask;
   logic              has_sm_data;
   logic [511:0]      sm_data;
   logic [WAY_W-1:0]  sm_fill_way;
   logic [WAY_W-1:0]  replace_l2_way;

   modport master (
      output l2req_valid, l2req_core, l2req_unit, l2req_strand, l2req_op, l2req_way,
             l2req_address, l2req_data, l2req_mask, has_sm_data, sm_data, sm_fill_way,
             replace_l2_way
   );

   modport slave (
      input  l2req_valid, l2req_core, l2req_unit, l2req_strand, l2req_op, l2req_way,
             l2req_address, l2req_data, l2req_mask, has_sm_data, sm_data, sm_fill_way,
             replace_l2_way
   );
endinterface

// File: rtl/l2_cache_dir_sharers.sv
// L2 directory stage: tag compare, per-line dirty and sharer tracking, and L1 invalidate mask.
// A post-reset sweep clears all directory state before requests are accepted.
module l2_cache_dir_sharers #(
   parameter int unsigned NUM_WAYS  = 4,
   parameter int unsigned NUM_CORES = 2,
   parameter int unsigned NUM_SETS  = 64,
   localparam int unsigned SET_W     = $clog2(NUM_SETS),
   localparam int unsigned TAG_WIDTH = 26 - SET_W,
   localparam int unsigned WAY_W     = $clog2(NUM_WAYS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall_pipeline,
   l2_cache_dir_sharers_if.slave         tag,
   input  logic [NUM_WAYS*TAG_WIDTH-1:0] tag_l2_tags,
   input  logic [NUM_WAYS-1:0]           tag_l2_valids,
   l2_cache_dir_sharers_if.master        dir,
   output logic                          dir_cache_hit,
   output logic [WAY_W-1:0]              dir_hit_l2_way,
   output logic [TAG_WIDTH-1:0]          dir_old_l2_tag,
   output logic [NUM_WAYS-1:0]           dir_l2_dirty,
   output logic [NUM_CORES-1:0]          dir_sharers,
   output logic [NUM_CORES-1:0]          dir_invalidate_mask,
   output logic                          dir_init_busy
);
   localparam logic [2:0] L2REQ_LOAD       = 3'd0;
   localparam logic [2:0] L2REQ_STORE      = 3'd1;
   localparam logic [2:0] L2REQ_FLUSH      = 3'd2;
   localparam logic [2:0] L2REQ_LOAD_SYNC  = 3'd4;
   localparam logic [2:0] L2REQ_STORE_SYNC = 3'd5;
   localparam logic [1:0] UNIT_DCACHE      = 2'd1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [SET_W-1:0] init_set_q, init_set_d;

   logic [NUM_WAYS-1:0]  dirty_mem  [NUM_SETS];
   logic [NUM_CORES-1:0] sharer_mem [NUM_SETS][NUM_WAYS];

   logic [TAG_WIDTH-1:0] req_tag;
   logic [SET_W-1:0]     req_set;
   logic [NUM_WAYS-1:0]  hit_vec;
   logic                 hit_any;
   logic [WAY_W-1:0]     hit_way, sel_way;
   logic [TAG_WIDTH-1:0] old_tag;
   logic [NUM_WAYS-1:0]  rd_dirty;
   logic [NUM_CORES-1:0] old_sh, core_oh, inval, wr_sh_val;
   logic                 is_load, is_store, is_flush, is_dcache;
   logic                 wr_dirty_en, wr_dirty_val, wr_sh_en, upd_en, req_run;

   // Sweep sequencer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_INIT;
         init_set_q <= '0;
      end else begin
         state_q    <= state_d;
         init_set_q <= init_set_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_set_d = init_set_q;
      case (state_q)
         S_INIT: begin
            init_set_d = init_set_q + SET_W'(1);
            if (init_set_q == SET_W'(NUM_SETS - 1)) state_d = S_RUN;
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_INIT;
      endcase
   end

   // Tag compare; lowest matching way wins
   always_comb begin
      req_tag = tag.l2req_address[25:SET_W];
      req_set = tag.l2req_address[SET_W-1:0];
      hit_way = '0;
      for (int i = 0; i < NUM_WAYS; i++)
         hit_vec[i] = tag_l2_valids[i] && (tag_l2_tags[i*TAG_WIDTH +: TAG_WIDTH] == req_tag);
      for (int i = NUM_WAYS - 1; i >= 0; i--)
         if (hit_vec[i]) hit_way = WAY_W'(i);
      hit_any = |hit_vec;
      sel_way = tag.has_sm_data ? tag.sm_fill_way : hit_way;
      old_tag = '0;
      for (int i = 0; i < NUM_WAYS; i++)
         if (WAY_W'(i) == sel_way) old_tag = tag_l2_tags[i*TAG_WIDTH +: TAG_WIDTH];
   end

   // Directory update decision for the request in the tag stage
   always_comb begin
      rd_dirty     = dirty_mem[req_set];
      old_sh       = sharer_mem[req_set][sel_way];
      core_oh      = NUM_CORES'(1) << tag.l2req_core;
      is_load      = (tag.l2req_op == L2REQ_LOAD) || (tag.l2req_op == L2REQ_LOAD_SYNC);
      is_store     = (tag.l2req_op == L2REQ_STORE) || (tag.l2req_op == L2REQ_STORE_SYNC);
      is_flush     = (tag.l2req_op == L2REQ_FLUSH);
      is_dcache    = (tag.l2req_unit == UNIT_DCACHE);
      wr_dirty_en  = 1'b0;
      wr_dirty_val = 1'b0;
      wr_sh_en     = 1'b0;
      wr_sh_val    = '0;
      inval        = '0;
      if (tag.has_sm_data) begin
         wr_dirty_en  = 1'b1;
         wr_dirty_val = is_store;
         wr_sh_en     = 1'b1;
         wr_sh_val    = (is_load && is_dcache) ? core_oh : '0;
         inval        = old_sh;
      end else if (hit_any) begin
         if (is_load && is_dcache) begin
            wr_sh_en  = 1'b1;
            wr_sh_val = old_sh | core_oh;
         end else if (is_store) begin
            wr_dirty_en  = 1'b1;
            wr_dirty_val = 1'b1;
            wr_sh_en     = 1'b1;
            wr_sh_val    = old_sh & core_oh;
            inval        = old_sh & ~core_oh;
         end else if (is_flush) begin
            wr_dirty_en  = 1'b1;
            wr_dirty_val = 1'b0;
         end
      end
      req_run = tag.l2req_valid && (state_q == S_RUN);
      upd_en  = req_run && !stall_pipeline && !reset;
   end

   // Dirty and sharer arrays; the sweep has priority over request updates
   always_ff @(posedge clk) begin
      if (state_q == S_INIT) begin
         dirty_mem[init_set_q] <= '0;
         for (int w = 0; w < NUM_WAYS; w++) sharer_mem[init_set_q][w] <= '0;
      end else if (upd_en) begin
         if (wr_dirty_en) dirty_mem[req_set][sel_way] <= wr_dirty_val;
         if (wr_sh_en)    sharer_mem[req_set][sel_way] <= wr_sh_val;
      end
   end

   // Stage registers
   always_ff @(posedge clk) begin
      if (reset) begin
         dir.l2req_valid     <= 1'b0;
         dir.l2req_core      <= '0;
         dir.l2req_unit      <= '0;
         dir.l2req_strand    <= '0;
         dir.l2req_op        <= '0;
         dir.l2req_way       <= '0;
         dir.l2req_address   <= '0;
         dir.l2req_data      <= '0;
         dir.l2req_mask      <= '0;
         dir.has_sm_data     <= 1'b0;
         dir.sm_data         <= '0;
         dir.sm_fill_way     <= '0;
         dir.replace_l2_way  <= '0;
         dir_cache_hit       <= 1'b0;
         dir_hit_l2_way      <= '0;
         dir_old_l2_tag      <= '0;
         dir_l2_dirty        <= '0;
         dir_sharers         <= '0;
         dir_invalidate_mask <= '0;
         dir_init_busy       <= 1'b1;
      end else begin
         dir_init_busy <= (state_d == S_INIT);
         if (!stall_pipeline) begin
            dir.l2req_valid     <= req_run;
            dir.l2req_core      <= tag.l2req_core;
            dir.l2req_unit      <= tag.l2req_unit;
            dir.l2req_strand    <= tag.l2req_strand;
            dir.l2req_op        <= tag.l2req_op;
            dir.l2req_way       <= tag.l2req_way;
            dir.l2req_address   <= tag.l2req_address;
            dir.l2req_data      <= tag.l2req_data;
            dir.l2req_mask      <= tag.l2req_mask;
            dir.has_sm_data     <= tag.has_sm_data;
            dir.sm_data         <= tag.sm_data;
            dir.sm_fill_way     <= tag.sm_fill_way;
            dir.replace_l2_way  <= tag.replace_l2_way;
            dir_cache_hit       <= hit_any;
            dir_hit_l2_way      <= hit_way;
            dir_old_l2_tag      <= old_tag;
            dir_l2_dirty        <= rd_dirty & tag_l2_valids;
            dir_sharers         <= req_run ? old_sh : '0;
            dir_invalidate_mask <= req_run ? inval : '0;
         end
      end
   end

   multi_hit: assert property (@(posedge clk) disable iff (reset)
      (state_q == S_RUN && tag.l2req_valid) |-> $onehot0(hit_vec));

endmodule
